int2flt_seq: RTL and testbench

- Multicycle hardware int-to-float stage, directly upstream of the float-to-int program.
- Reads a 16-bit two's-complement integer from byte-wide data memory at SRC_ADDR (low byte) and SRC_ADDR+1 (high byte).
- Converts it to IEEE-754 half precision and writes the result to DST_ADDR (low byte) and DST_ADDR+1 (high byte).
- Uses the same start/done handshake as the program-level converters, so benches can swap it in alongside them.

---
 rtl/int2flt_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_int2flt_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int2flt_seq.sv
// ---------------------------------------------------------------------------
// int2flt_seq
//
// Multicycle int16 -> IEEE-754 half-precision converter working through a
// byte-wide data memory. It reads a two's-complement integer from SRC_ADDR
// (low byte) and SRC_ADDR+1 (high byte). It converts the value with a
// one-bit-per-cycle normaliser. It writes the half-precision result to
// DST_ADDR (low byte) and DST_ADDR+1 (high byte). The start/done handshake
// matches the program-level converters, so either one can drive the same
// bench.
//
// Parameters:
//   SRC_ADDR    byte address of the integer's low byte (default 0)
//   DST_ADDR    byte address of the result's low byte  (default 2)
//
// Ports:
//   clk          in   1  single clock, rising edge
//   reset        in   1  asynchronous, active-low reset
//   start        in   1  begin conversion; sampled only in IDLE and FIN
//   done         out  1  conversion complete; held until the next accepted start
//   mem_addr     out  8  data memory byte address (wraps modulo 256)
//   mem_rd_data  in   8  combinational read data for mem_addr
//   mem_wr_en    out  1  write strobe, one cycle per result byte
//   mem_wr_data  out  8  write data
//
// Configuration macro:
//   INT2FLT_ROUND_NEAREST_EN  defined   -> round-to-nearest-even
//                             undefined -> truncate (guard/sticky ignored)
//   Latency is identical in both builds.
//
// Latency (clock edges from the accepting edge E0 until done=1):
//   nonzero input: 7 + k, where k = 15 - (msb position of |x|)
//   zero input:    6
// ---------------------------------------------------------------------------
module int2flt_seq #(
   parameter logic [7:0] SRC_ADDR = 8'd0,
   parameter logic [7:0] DST_ADDR = 8'd2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       done,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rd_data,
   output logic       mem_wr_en,
   output logic [7:0] mem_wr_data
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_ABS,
      S_NORM,
      S_PACK,
      S_WR_LO,
      S_WR_HI,
      S_FIN
   } state_t;

   // Exponent of a value whose leading one sits at bit 15: bias 15 + 15.
   localparam logic [4:0] EXP_TOP = 5'd30;

   // Address increments are done in 8 bits, so they wrap modulo 256.
   localparam logic [7:0] SRC_ADDR_HI = SRC_ADDR + 8'd1;
   localparam logic [7:0] DST_ADDR_HI = DST_ADDR + 8'd1;

   state_t      state_q,  state_d;
   logic [7:0]  lo_q,     lo_d;      // captured low byte of the integer
   logic [7:0]  hi_q,     hi_d;      // captured high byte of the integer
   logic        sign_q,   sign_d;
   logic        zero_q,   zero_d;    // input was exactly zero
   logic [15:0] mag_q,    mag_d;     // magnitude, left-justified during NORM
   logic [4:0]  exp_q,    exp_d;     // biased exponent tracking the shifts
   logic [15:0] result_q, result_d;  // packed half-precision result

   // ------------------------------------------------------------------------
   // Datapath helpers
   // ------------------------------------------------------------------------
   logic [15:0] x_int;
   logic [15:0] x_mag;

   assign x_int = {hi_q, lo_q};
   // The magnitude is unsigned 16-bit. Negating 0x8000 gives 0x8000, which
   // is the correct magnitude 32768, so no 17th bit is needed.
   assign x_mag = x_int[15] ? (~x_int + 16'd1) : x_int;

   // Once normalised, bit 15 is the hidden one and the next ten bits are the
   // stored mantissa. The remaining five bits feed rounding.
   logic [9:0] mant_trunc;
   logic [9:0] mant_r;
   logic [4:0] exp_r;

   assign mant_trunc = mag_q[14:5];

`ifdef INT2FLT_ROUND_NEAREST_EN
   logic        guard;
   logic        sticky;
   logic [10:0] mant_inc;

   assign guard  = mag_q[4];
   assign sticky = |mag_q[3:0];

   always_comb begin
      mant_inc = {1'b0, mant_trunc} + 11'(guard & (sticky | mant_trunc[0]));
      if (mant_inc[10]) begin
         // A mantissa overflow renormalises to the next binade. This can only
         // happen for exp <= 29: the one value with exp 30 is 0x8000, and its
         // low bits are all zero. So the exponent never reaches 31.
         mant_r = 10'd0;
         exp_r  = exp_q + 5'd1;
      end else begin
         mant_r = mant_inc[9:0];
         exp_r  = exp_q;
      end
   end
`else
   logic unused_round_bits;

   assign unused_round_bits = ^mag_q[4:0];
   assign mant_r            = mant_trunc;
   assign exp_r             = exp_q;
`endif

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal this block writes gets a default here first. A
      // branch that forgets one cannot then infer a latch.
      state_d     = state_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      sign_d      = sign_q;
      zero_d      = zero_q;
      mag_d       = mag_q;
      exp_d       = exp_q;
      result_d    = result_q;
      done        = 1'b0;
      mem_addr    = SRC_ADDR;
      mem_wr_en   = 1'b0;
      mem_wr_data = 8'd0;

      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RD_LO;
         end

         S_RD_LO: begin
            mem_addr = SRC_ADDR;
            lo_d     = mem_rd_data;
            state_d  = S_RD_HI;
         end

         S_RD_HI: begin
            mem_addr = SRC_ADDR_HI;
            hi_d     = mem_rd_data;
            state_d  = S_ABS;
         end

         S_ABS: begin
            sign_d  = x_int[15];
            mag_d   = x_mag;
            exp_d   = EXP_TOP;
            zero_d  = (x_int == 16'd0);
            state_d = (x_int == 16'd0) ? S_PACK : S_NORM;
         end

         S_NORM: begin
            // This state takes one cycle per leading zero, plus one final
            // cycle that sees the leading one at bit 15.
            if (mag_q[15]) begin
               state_d = S_PACK;
            end else begin
               mag_d = {mag_q[14:0], 1'b0};
               exp_d = exp_q - 5'd1;
            end
         end

         S_PACK: begin
            // Zero packs to +0. The sign is dropped so -0 is never written.
            result_d = zero_q ? 16'h0000 : {sign_q, exp_r, mant_r};
            state_d  = S_WR_LO;
         end

         S_WR_LO: begin
            mem_addr    = DST_ADDR;
            mem_wr_data = result_q[7:0];
            mem_wr_en   = 1'b1;
            state_d     = S_WR_HI;
         end

         S_WR_HI: begin
            mem_addr    = DST_ADDR_HI;
            mem_wr_data = result_q[15:8];
            mem_wr_en   = 1'b1;
            state_d     = S_FIN;
         end

         S_FIN: begin
            done = 1'b1;
            if (start) state_d = S_RD_LO;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   // NOTE: the datapath registers are reset along with the state. A reset
   // then always gives the same internal state, even in the middle of a
   // conversion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         lo_q     <= 8'd0;
         hi_q     <= 8'd0;
         sign_q   <= 1'b0;
         zero_q   <= 1'b0;
         mag_q    <= 16'd0;
         exp_q    <= 5'd0;
         result_q <= 16'd0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples the
         // pre-edge values no matter what order these statements are in.
         state_q  <= state_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         sign_q   <= sign_d;
         zero_q   <= zero_d;
         mag_q    <= mag_d;
         exp_q    <= exp_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_int2flt_seq.sv
// Self-checking bench for int2flt_seq: directed table, corner sequences,
// randomized vectors against an arithmetic reference model.
module tb_int2flt_seq;

   localparam logic [7:0] SRC = 8'd0;
   localparam logic [7:0] DST = 8'd2;
   localparam int         MAX_EDGES = 200;

`ifdef INT2FLT_ROUND_NEAREST_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       start;
   logic       done;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;

   int checks = 0;
   int errors = 0;

   int2flt_seq #(.SRC_ADDR(SRC), .DST_ADDR(DST)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte memory: DUT writes and bench preloads both go through this block.
   logic [7:0] mem [256];
   logic       tb_we;
   logic [7:0] tb_addr;
   logic [7:0] tb_data;
   int         wr_count = 0;
   int         stray_wr = 0;

   assign mem_rd_data = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_wr_en) begin
         mem[mem_addr] <= mem_wr_data;
         wr_count      <= wr_count + 1;
         if (mem_addr != DST && mem_addr != DST + 8'd1) stray_wr <= stray_wr + 1;
      end else if (tb_we) begin
         mem[tb_addr] <= tb_data;
      end
   end

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      tb_we   = 1'b1;
      tb_addr = a;
      tb_data = d;
      @(negedge clk);
      tb_we   = 1'b0;
   endtask

   // Reference: real-valued rounding of |x| to 11 significant bits.
   function automatic logic [15:0] ref_half(input logic [15:0] x);
      int v, m, e, q, r;
      bit s;
      v = int'($signed(x));
      s = (v < 0);
      m = s ? -v : v;
      if (m == 0) return 16'h0000;
      e = 0;
      while ((m >> (e + 1)) != 0) e++;
      q = (m * 1024) >> e;          // 1024 <= q < 2048
      r = (m * 1024) - (q << e);    // remainder in units of 2^-e
      if (RNE) begin
         if (2 * r > (1 << e) || (2 * r == (1 << e) && (q % 2) == 1)) q++;
      end
      if (q == 2048) begin
         q = 1024;
         e++;
      end
      return 16'((int'(s) << 15) | ((e + 15) << 10) | (q - 1024));
   endfunction

   function automatic int ref_latency(input logic [15:0] x);
      int v, m, e;
      v = int'($signed(x));
      m = (v < 0) ? -v : v;
      if (m == 0) return 6;
      e = 0;
      while ((m >> (e + 1)) != 0) e++;
      return 7 + (15 - e);
   endfunction

   // One conversion: preload, start, wait for done, report result/latency.
   // pulse_at >= 0 re-pulses start after that many edges (must be ignored).
   task automatic run_conv(input logic [15:0] x, input int pulse_at,
                           output logic [15:0] res, output int lat,
                           output int writes);
      int base;
      poke(SRC, x[7:0]);
      poke(SRC + 8'd1, x[15:8]);
      base = wr_count;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("done_cleared_at_e0", int'(done), 0);
      lat = 0;
      while (lat < MAX_EDGES) begin
         @(posedge clk);
         #1;
         lat++;
         if (start) start = 1'b0;
         if (lat == pulse_at) start = 1'b1;
         if (done) break;
      end
      start = 1'b0;
      if (!done) check("done_timeout", 0, 1);
      res    = {mem[DST + 8'd1], mem[DST]};
      writes = wr_count - base;
   endtask

   typedef struct {
      logic [15:0] x;
      logic [15:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [15:0] res, x;
      int          lat, writes, s0;

      vecs[0] = '{16'h0001, 16'h3C00, 22};
      vecs[1] = '{16'hFFFF, 16'hBC00, 22};
      vecs[2] = '{16'h0000, 16'h0000, 6};
      vecs[3] = '{16'h8000, 16'hF800, 7};
      vecs[4] = '{16'h7FFF, RNE ? 16'h7800 : 16'h77FF, 8};
      vecs[5] = '{16'h0803, RNE ? 16'h6802 : 16'h6801, 11};
      vecs[6] = '{16'h0801, 16'h6800, 11};
      vecs[7] = '{16'h0400, 16'h6400, 12};

      tb_we   = 1'b0;
      tb_addr = 8'd0;
      tb_data = 8'd0;
      start   = 1'b0;
      reset   = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      #1;
      check("rst_done", int'(done), 0);
      check("rst_wr_en", int'(mem_wr_en), 0);
      check("rst_addr", int'(mem_addr), int'(SRC));
      check("rst_wr_data", int'(mem_wr_data), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         s0 = stray_wr;
         run_conv(vecs[i].x, -1, res, lat, writes);
         check($sformatf("tbl%0d_result", i), int'(res), int'(vecs[i].res));
         check($sformatf("tbl%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("tbl%0d_writes", i), writes, 2);
         check($sformatf("tbl%0d_stray", i), stray_wr - s0, 0);
      end

      // Back-to-back: done holds in FIN, then drops at the accepting edge.
      repeat (3) @(negedge clk);
      check("fin_done_held", int'(done), 1);
      run_conv(16'hD8F1, -1, res, lat, writes);
      check("b2b_result", int'(res), int'(ref_half(16'hD8F1)));
      check("b2b_latency", lat, ref_latency(16'hD8F1));

      // A start pulse during NORM is ignored.
      run_conv(16'h0001, 6, res, lat, writes);
      check("norm_pulse_result", int'(res), 16'h3C00);
      check("norm_pulse_latency", lat, 22);
      check("norm_pulse_writes", writes, 2);

      // Reset during WR_LO aborts the conversion and issues no writes.
      poke(DST, 8'hAA);
      poke(DST + 8'd1, 8'h55);
      poke(SRC, 8'h01);
      poke(SRC + 8'd1, 8'h00);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      check("abort_in_wr_lo", int'(mem_wr_en), 1);
      check("abort_wr_lo_addr", int'(mem_addr), int'(DST));
      reset = 1'b0;
      #1;
      check("abort_done", int'(done), 0);
      check("abort_wr_en", int'(mem_wr_en), 0);
      check("abort_addr", int'(mem_addr), int'(SRC));
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_wr_lo", int'(mem[DST]), 8'hAA);
      check("abort_no_wr_hi", int'(mem[DST + 8'd1]), 8'h55);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_idle_done", int'(done), 0);
      run_conv(16'hFFFF, -1, res, lat, writes);
      check("post_reset_result", int'(res), 16'hBC00);
      check("post_reset_latency", lat, 22);

      // Randomized vectors against the reference model.
      for (int i = 0; i < 40; i++) begin
         x = 16'($urandom_range(0, 65535));
         if (i % 4 == 1) x = 16'($urandom_range(0, 15));
         if (i % 4 == 2) x = 16'(-$urandom_range(1, 15));
         run_conv(x, -1, res, lat, writes);
         check($sformatf("rnd_%04h_result", x), int'(res), int'(ref_half(x)));
         check($sformatf("rnd_%04h_latency", x), lat, ref_latency(x));
         check($sformatf("rnd_%04h_writes", x), writes, 2);
      end
      check("no_stray_writes", stray_wr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
